// File: rtl/alu_mul_seq.sv
// Sequential 12x12 shift-add multiplier that drives an external combinational ALU as its datapath.
// Optional MUL_SIGNED_EN adds req_signed and a two-step two's-complement correction.
module alu_mul_seq #(
    parameter int unsigned ITER = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_a,
    input  logic [11:0] req_b,
`ifdef MUL_SIGNED_EN
    input  logic        req_signed,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [23:0] resp_prod,
    output logic        resp_zero,
    output logic [11:0] alu_a,
    output logic [11:0] alu_b,
    output logic [4:0]  alu_op,
    output logic [3:0]  alu_cond,
    output logic [4:0]  alu_flg_in,
    input  logic [11:0] alu_q,
    input  logic [4:0]  alu_flg_out
);

    localparam logic [4:0] OpNop = 5'h00;
    localparam logic [4:0] OpAdd = 5'h04;
    localparam logic [4:0] OpSub = 5'h06;
    localparam logic [4:0] OpRrc = 5'h0b;
    localparam logic [3:0] CntLast = 4'(ITER - 1);

    typedef enum logic [2:0] {
        StIdle, StAdd, StRhi, StRlo, StCa, StCb, StDone
    } state_t;

    state_t      state_q;
    logic [11:0] mcand_q;
    logic [11:0] hi_q;
    logic [11:0] lo_q;
    logic        k_q;
    logic [3:0]  cnt_q;
`ifdef MUL_SIGNED_EN
    logic        sgn_q;
    logic [11:0] b_orig_q;
`endif

    // Only the carry flag feeds back into the sequence.
    logic unused_flg;
    assign unused_flg = ^{alu_flg_out[4:3], alu_flg_out[1:0]};

    assign alu_cond = 4'hf;

    always_comb begin
        alu_op     = OpNop;
        alu_a      = '0;
        alu_b      = '0;
        alu_flg_in = '0;
        case (state_q)
            StAdd: begin
                alu_op = OpAdd;
                alu_a  = hi_q;
                alu_b  = lo_q[0] ? mcand_q : 12'h000;
            end
            StRhi: begin
                alu_op     = OpRrc;
                alu_b      = hi_q;
                alu_flg_in = {2'b00, k_q, 2'b00};
            end
            StRlo: begin
                alu_op     = OpRrc;
                alu_b      = lo_q;
                alu_flg_in = {2'b00, k_q, 2'b00};
            end
`ifdef MUL_SIGNED_EN
            // Subtract the cross terms that the unsigned product over-counts for negative operands.
            StCa: begin
                alu_op = OpSub;
                alu_a  = hi_q;
                alu_b  = (sgn_q & mcand_q[11]) ? b_orig_q : 12'h000;
            end
            StCb: begin
                alu_op = OpSub;
                alu_a  = hi_q;
                alu_b  = (sgn_q & b_orig_q[11]) ? mcand_q : 12'h000;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            k_q        <= 1'b0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_prod  <= '0;
            resp_zero  <= 1'b1;
`ifdef MUL_SIGNED_EN
            sgn_q      <= 1'b0;
            b_orig_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        mcand_q   <= req_a;
                        lo_q      <= req_b;
                        hi_q      <= '0;
                        k_q       <= 1'b0;
                        cnt_q     <= '0;
                        req_ready <= 1'b0;
`ifdef MUL_SIGNED_EN
                        sgn_q     <= req_signed;
                        b_orig_q  <= req_b;
`endif
                        state_q   <= StAdd;
                    end
                end
                StAdd: begin
                    hi_q    <= alu_q;
                    k_q     <= alu_flg_out[2];
                    state_q <= StRhi;
                end
                StRhi: begin
                    hi_q    <= alu_q;
                    k_q     <= alu_flg_out[2];
                    state_q <= StRlo;
                end
                StRlo: begin
                    lo_q <= alu_q;
                    if (cnt_q == CntLast) begin
`ifdef MUL_SIGNED_EN
                        state_q    <= StCa;
`else
                        state_q    <= StDone;
                        resp_valid <= 1'b1;
                        resp_prod  <= {hi_q, alu_q};
                        resp_zero  <= ({hi_q, alu_q} == 24'h000000);
`endif
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        state_q <= StAdd;
                    end
                end
`ifdef MUL_SIGNED_EN
                StCa: begin
                    hi_q    <= alu_q;
                    state_q <= StCb;
                end
                StCb: begin
                    hi_q       <= alu_q;
                    state_q    <= StDone;
                    resp_valid <= 1'b1;
                    resp_prod  <= {alu_q, lo_q};
                    resp_zero  <= ({alu_q, lo_q} == 24'h000000);
                end
`endif
                StDone: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the Computer12 ALU ops it uses.
// Define MUL_SIGNED_EN to also exercise the signed-correction build.
module tb_alu_mul_seq;

`ifdef MUL_SIGNED_EN
    localparam int ExpLat = 38;
`else
    localparam int ExpLat = 36;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_a;
    logic [11:0] req_b;
`ifdef MUL_SIGNED_EN
    logic        req_signed;
`endif
    logic        resp_valid;
    logic        resp_ready;
    logic [23:0] resp_prod;
    logic        resp_zero;
    logic [11:0] alu_a;
    logic [11:0] alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_cond;
    logic [4:0]  alu_flg_in;
    logic [11:0] alu_q;
    logic [4:0]  alu_flg_out;

    int vectors;
    int miscompares;

    alu_mul_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
`ifdef MUL_SIGNED_EN
        .req_signed  (req_signed),
`endif
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_prod   (resp_prod),
        .resp_zero   (resp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cond    (alu_cond),
        .alu_flg_in  (alu_flg_in),
        .alu_q       (alu_q),
        .alu_flg_out (alu_flg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: 04 add, 06 subtract, 0b rotate B right through carry. Flags {P,V,K,S,Z}.
    logic [12:0] alu_tmp;
    always_comb begin
        alu_tmp     = '0;
        alu_q       = '0;
        alu_flg_out = '0;
        case (alu_op)
            5'h04: begin
                alu_tmp        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_q          = alu_tmp[11:0];
                alu_flg_out[2] = alu_tmp[12];
            end
            5'h06: begin
                alu_tmp        = {1'b0, alu_a} - {1'b0, alu_b};
                alu_q          = alu_tmp[11:0];
                alu_flg_out[2] = alu_tmp[12];
            end
            5'h0b: begin
                alu_q          = {alu_flg_in[2], alu_b[11:1]};
                alu_flg_out[2] = alu_b[0];
            end
            default: alu_q = '0;
        endcase
        alu_flg_out[4] = alu_flg_in[4];
        alu_flg_out[1] = alu_q[11];
        alu_flg_out[0] = (alu_q == 12'h000);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for req_ready, then presents one request across an accepting edge.
    task automatic send(input logic [11:0] a, input logic [11:0] b);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!resp_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
`ifdef MUL_SIGNED_EN
        req_signed = 1'b0;
`endif
        #1;
        vectors += 6;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_resp_valid got %b want 0", resp_valid);
        end
        if (resp_prod !== 24'h000000) begin
            miscompares++; $display("FAIL reset_prod got %h want 000000", resp_prod);
        end
        if (resp_zero !== 1'b1) begin
            miscompares++; $display("FAIL reset_zero got %b want 1", resp_zero);
        end
        if (alu_op !== 5'h00) begin
            miscompares++; $display("FAIL reset_alu_op got %h want 00", alu_op);
        end
        if (alu_cond !== 4'hf) begin
            miscompares++; $display("FAIL reset_alu_cond got %h want f", alu_cond);
        end
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int lat;
        resp_ready = 1'b1;
        send(12'h003, 12'h005);
        wait_valid(lat);
        vectors += 6;
        if (lat !== ExpLat) begin
            miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, ExpLat);
        end
        if (resp_prod !== 24'h00000F) begin
            miscompares++; $display("FAIL basic_prod got %h want 00000f", resp_prod);
        end
        if (resp_zero !== 1'b0) begin
            miscompares++; $display("FAIL basic_zero got %b want 0", resp_zero);
        end
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL basic_ready_in_done got %b want 0", req_ready);
        end
        tick();
        if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_valid_drop got %b want 0", resp_valid);
        end
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL basic_ready_back got %b want 1", req_ready);
        end
    endtask

    task automatic test_alu_seq;
        int lat;
        logic [4:0] exp_op;
        resp_ready = 1'b1;
        send(12'hFFF, 12'hFFF);
        for (int i = 0; i < 36; i++) begin
            exp_op = (i % 3 == 0) ? 5'h04 : 5'h0b;
            vectors++;
            if (alu_op !== exp_op) begin
                miscompares++; $display("FAIL alu_op_cycle%0d got %h want %h", i, alu_op, exp_op);
            end
            if (i % 3 == 0) begin
                vectors++;
                if (alu_b !== 12'hFFF) begin
                    miscompares++; $display("FAIL alu_b_add%0d got %h want fff", i, alu_b);
                end
            end
            tick();
        end
        wait_valid(lat);
        vectors += 3;
        if (lat + 36 !== ExpLat) begin
            miscompares++; $display("FAIL ffxff_latency got %0d want %0d", lat + 36, ExpLat);
        end
        if (resp_prod !== 24'hFFE001) begin
            miscompares++; $display("FAIL ffxff_prod got %h want ffe001", resp_prod);
        end
        if (alu_op !== 5'h00) begin
            miscompares++; $display("FAIL done_alu_op got %h want 00", alu_op);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int lat;
        resp_ready = 1'b1;
        send(12'h123, 12'h456);
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL busy_ready got %b want 0", req_ready);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors += 4;
        if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_valid got %b want 0", resp_valid);
        end
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_ready got %b want 1", req_ready);
        end
        if (resp_prod !== 24'h000000) begin
            miscompares++; $display("FAIL rstmid_prod got %h want 000000", resp_prod);
        end
        if (alu_op !== 5'h00) begin
            miscompares++; $display("FAIL rstmid_alu_op got %h want 00", alu_op);
        end
        @(negedge clk);
        rst = 1'b0;
        send(12'h010, 12'h010);
        wait_valid(lat);
        vectors += 3;
        if (lat !== ExpLat) begin
            miscompares++; $display("FAIL after_rst_latency got %0d want %0d", lat, ExpLat);
        end
        if (resp_prod !== 24'h000100) begin
            miscompares++; $display("FAIL after_rst_prod got %h want 000100", resp_prod);
        end
        if (resp_zero !== 1'b0) begin
            miscompares++; $display("FAIL after_rst_zero got %b want 0", resp_zero);
        end
        tick();
    endtask

    task automatic test_hold_zero;
        int lat;
        resp_ready = 1'b0;
        send(12'h000, 12'hABC);
        wait_valid(lat);
        vectors += 3;
        if (lat !== ExpLat) begin
            miscompares++; $display("FAIL zero_latency got %0d want %0d", lat, ExpLat);
        end
        if (resp_prod !== 24'h000000) begin
            miscompares++; $display("FAIL zero_prod got %h want 000000", resp_prod);
        end
        if (resp_zero !== 1'b1) begin
            miscompares++; $display("FAIL zero_flag got %b want 1", resp_zero);
        end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_a     = 12'h007;
            req_b     = 12'h009;
            tick();
            vectors += 3;
            if (resp_valid !== 1'b1) begin
                miscompares++; $display("FAIL hold_valid%0d got %b want 1", i, resp_valid);
            end
            if (resp_prod !== 24'h000000) begin
                miscompares++; $display("FAIL hold_prod%0d got %h want 000000", i, resp_prod);
            end
            if (req_ready !== 1'b0) begin
                miscompares++; $display("FAIL hold_ready%0d got %b want 0", i, req_ready);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        vectors += 2;
        if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL release_valid got %b want 0", resp_valid);
        end
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL release_ready got %b want 1", req_ready);
        end
        tick();
        tick();
        vectors += 2;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL busy_req_ignored got ready %b want 1", req_ready);
        end
        if (resp_prod !== 24'h000000) begin
            miscompares++; $display("FAIL prod_held got %h want 000000", resp_prod);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] ta [3] = '{12'h123, 12'hFFF, 12'h800};
        logic [11:0] tb [3] = '{12'h456, 12'h001, 12'h800};
        logic [23:0] tp [3] = '{24'h04EDC2, 24'h000FFF, 24'h400000};
        int lat;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb[i]);
            wait_valid(lat);
            vectors += 3;
            if (lat !== ExpLat) begin
                miscompares++; $display("FAIL b2b_latency%0d got %0d want %0d", i, lat, ExpLat);
            end
            if (resp_prod !== tp[i]) begin
                miscompares++; $display("FAIL b2b_prod%0d got %h want %h", i, resp_prod, tp[i]);
            end
            if (req_ready !== 1'b0) begin
                miscompares++; $display("FAIL b2b_ready%0d got %b want 0", i, req_ready);
            end
        end
        tick();
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed;
        logic        ts [3] = '{1'b1, 1'b1, 1'b0};
        logic [11:0] ta [3] = '{12'hFFE, 12'hFFF, 12'hFFF};
        logic [11:0] tb [3] = '{12'h003, 12'hFFF, 12'hFFF};
        logic [23:0] tp [3] = '{24'hFFFFFA, 24'h000001, 24'hFFE001};
        int lat;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_signed = ts[i];
            send(ta[i], tb[i]);
            wait_valid(lat);
            vectors += 2;
            if (lat !== 38) begin
                miscompares++; $display("FAIL signed_latency%0d got %0d want 38", i, lat);
            end
            if (resp_prod !== tp[i]) begin
                miscompares++; $display("FAIL signed_prod%0d got %h want %h", i, resp_prod, tp[i]);
            end
        end
        tick();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_alu_seq();
        test_reset_mid();
        test_hold_zero();
        test_back_to_back();
`ifdef MUL_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
